// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_arb_pkg;

  // Arbiter states: normal read-priority operation, or a reserved write slot.
  typedef enum logic [0:0] {
    S_NORM    = 1'b0,
    S_WR_RESV = 1'b1
  } arb_state_t;

  // Width of the optional statistics counters.
  localparam int unsigned STAT_W = 16;

  // Default geometry and timing.
  localparam int unsigned DEF_AWIDTH       = 19;
  localparam int unsigned DEF_PWIDTH       = 8;
  localparam int unsigned DEF_MEM_LATENCY  = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// VGA read, pixel write and memory command signals of the VRAM arbiter.
// slave: arbiter side; master: the surrounding VGA/drawing/memory side.
interface vram_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned PWIDTH = DEF_PWIDTH
);

  logic              vga_rd;
  logic [AWIDTH-1:0] vga_addr;
  logic              vga_busy;
  logic [PWIDTH-1:0] vga_data;
  logic              vga_vld;

  logic              wr_req;
  logic [AWIDTH-1:0] wr_addr;
  logic [PWIDTH-1:0] wr_data;
  logic              wr_ack;

  logic              mem_rd;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [PWIDTH-1:0] mem_wdata;
  logic [PWIDTH-1:0] mem_rdata;

  logic              rd_err;

  modport slave (
    input  vga_rd, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output vga_busy, vga_data, vga_vld, wr_ack,
           mem_rd, mem_we, mem_addr, mem_wdata, rd_err
  );

  modport master (
    output vga_rd, vga_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  vga_busy, vga_data, vga_vld, wr_ack,
           mem_rd, mem_we, mem_addr, mem_wdata, rd_err
  );

endinterface

// File: rtl/vram_rd_tracker.sv
// Read return path: follows each accepted read through the memory latency
// and captures the returned pixel into a register.
module vram_rd_tracker
  import vram_arb_pkg::*;
#(
  parameter int unsigned PWIDTH      = DEF_PWIDTH,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic              rd_issue,
  input  logic [PWIDTH-1:0] mem_rdata,
  output logic [PWIDTH-1:0] rd_data,
  output logic              rd_vld
);

  // Bit 0 lines up with the registered mem_rd; the top bit marks the cycle
  // in which mem_rdata holds that read's data.
  logic [MEM_LATENCY:0] vld_sr;

  // Valid shift register; reset drops every read in flight.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) vld_sr <= '0;
    else          vld_sr <= {vld_sr[MEM_LATENCY-1:0], rd_issue};
  end

  // Capture returning data and present it with its valid strobe.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld <= vld_sr[MEM_LATENCY];
      if (vld_sr[MEM_LATENCY]) rd_data <= mem_rdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads have priority, pixel writes are
// protected from starvation by reserving a slot (vga_busy) after
// STARVE_LIMIT consecutive blocked cycles.
// Optional statistics ports are enabled by defining VRAM_ARB_STAT_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AWIDTH       = DEF_AWIDTH,
  parameter int unsigned PWIDTH       = DEF_PWIDTH,
  parameter int unsigned MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk_core,
  input  logic rst_core,
  vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_resv
`endif
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_q;
  arb_state_t        state_next;
  logic [CW-1:0]     starve_cnt;
  logic              starve_hit;
  logic              rd_accept;
  logic              wr_grant;
  logic              busy_q;
  logic              rd_err_q;
  logic              mem_rd_q;
  logic              mem_we_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [PWIDTH-1:0] mem_wdata_q;
  logic [PWIDTH-1:0] rd_data;
  logic              rd_vld;

  // A write blocked by a read for the last allowed time.
  assign starve_hit = bus.vga_rd && bus.wr_req &&
                      (starve_cnt == CW'(STARVE_LIMIT - 1));

  // State register.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) state_q <= S_NORM;
    else          state_q <= state_next;
  end

  // Next-state: enter the reserved slot on starvation, leave on the write.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_NORM:    if (starve_hit) state_next = S_WR_RESV;
      S_WR_RESV: if (bus.wr_req) state_next = S_NORM;
      default:   state_next = S_NORM;
    endcase
  end

  // Grant decode; nothing is granted while reset is asserted so a pending
  // write is never acked during reset.
  always_comb begin
    rd_accept = 1'b0;
    wr_grant  = 1'b0;
    if (!rst_core) begin
      case (state_q)
        S_NORM: begin
          rd_accept = bus.vga_rd;
          wr_grant  = !bus.vga_rd && bus.wr_req;
        end
        S_WR_RESV: wr_grant = bus.wr_req;
        default: ;
      endcase
    end
  end

  // Registered memory command; address and data hold when idle.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_rd_q <= rd_accept;
      mem_we_q <= wr_grant;
      if (rd_accept) begin
        mem_addr_q <= bus.vga_addr;
      end else if (wr_grant) begin
        mem_addr_q  <= bus.wr_addr;
        mem_wdata_q <= bus.wr_data;
      end
    end
  end

  // Starve counter: counts blocked cycles, holds when the write is
  // withdrawn, clears only when a write is granted.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      starve_cnt <= '0;
    end else if (wr_grant) begin
      starve_cnt <= '0;
    end else if (state_q == S_NORM && bus.vga_rd && bus.wr_req && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Busy flag toward VGA and sticky protocol-error flag.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      busy_q   <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      busy_q <= (state_next == S_WR_RESV);
      if (state_q == S_WR_RESV && bus.vga_rd) rd_err_q <= 1'b1;
    end
  end

  vram_rd_tracker #(
    .PWIDTH      (PWIDTH),
    .MEM_LATENCY (MEM_LATENCY)
  ) u_rd_tracker (
    .clk_core  (clk_core),
    .rst_core  (rst_core),
    .rd_issue  (rd_accept),
    .mem_rdata (bus.mem_rdata),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld)
  );

  assign bus.vga_busy  = busy_q;
  assign bus.vga_data  = rd_data;
  assign bus.vga_vld   = rd_vld;
  assign bus.wr_ack    = wr_grant;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_err    = rd_err_q;

`ifdef VRAM_ARB_STAT_EN
  // Saturating counts of stalled write cycles and reserved-slot entries.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      stat_stall <= '0;
      stat_resv  <= '0;
    end else begin
      if (bus.wr_req && !wr_grant) stat_stall <= sat_inc(stat_stall);
      if (state_q == S_NORM && state_next == S_WR_RESV) stat_resv <= sat_inc(stat_resv);
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a scoreboard of expected reads.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int unsigned AW = DEF_AWIDTH;
  localparam int unsigned PW = DEF_PWIDTH;
  localparam int unsigned ML = DEF_MEM_LATENCY;
  localparam int unsigned SL = DEF_STARVE_LIMIT;
  localparam int RD_LAT = ML + 2;

  typedef struct {
    logic [PW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [PW-1:0] mpipe [ML];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_arbiter_if #(.AWIDTH(AW), .PWIDTH(PW)) bus();

`ifdef VRAM_ARB_STAT_EN
  logic [STAT_W-1:0] stat_stall;
  logic [STAT_W-1:0] stat_resv;
`endif

  vram_arbiter #(
    .AWIDTH       (AW),
    .PWIDTH       (PW),
    .MEM_LATENCY  (ML),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk_core (clk),
    .rst_core (rst),
    .bus      (bus)
`ifdef VRAM_ARB_STAT_EN
    ,
    .stat_stall (stat_stall),
    .stat_resv  (stat_resv)
`endif
  );

  // Memory model: returns the address LSBs ML cycles after mem_rd.
  always @(posedge clk) begin
    mpipe[0] <= bus.mem_rd ? bus.mem_addr[PW-1:0] : 8'hEE;
    for (int i = ML - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mem_rdata = mpipe[ML-1];

  // Scoreboard consumer: every vga_vld must match the oldest expected read
  // in both data and arrival cycle.
  always @(negedge clk) begin
    if (bus.vga_vld === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got vld data=%0h cycle=%0d exp no valid", bus.vga_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.vga_data !== mon_e.data || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL rd_return got data=%0h cycle=%0d exp data=%0h cycle=%0d",
                   bus.vga_data, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic [AW-1:0] ra,
                       input logic wq, input logic [AW-1:0] wa, input logic [PW-1:0] wd);
    bus.vga_rd   = rd;
    bus.vga_addr = ra;
    bus.wr_req   = wq;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
  endtask

  task automatic push_rd(input logic [AW-1:0] ra);
    sb.push_back('{data: ra[PW-1:0], cyc: cyc + RD_LAT});
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: n cycles of read plus blocked write.
  task automatic run_blocked(input int n, input logic [AW-1:0] base,
                             input logic [AW-1:0] wa, input logic [PW-1:0] wd);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + AW'(i), 1'b1, wa, wd);
      push_rd(base + AW'(i));
      next_cycle();
    end
  endtask

  task automatic test_reset;
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checks++; if ({bus.mem_rd, bus.mem_we, bus.vga_busy, bus.vga_vld, bus.wr_ack, bus.rd_err} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {bus.mem_rd, bus.mem_we, bus.vga_busy, bus.vga_vld, bus.wr_ack, bus.rd_err}); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.vga_data !== '0) begin
      failures++; $display("FAIL reset_buses got addr=%0h wdata=%0h vdata=%0h exp 0",
        bus.mem_addr, bus.mem_wdata, bus.vga_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read;
    for (int k = 0; k < 20 && cyc < 10; k++) next_cycle();
    drive(1'b1, 19'h00123, 1'b0, '0, '0);
    push_rd(19'h00123);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL single_strobe got rd=%b we=%b exp rd=1 we=0", bus.mem_rd, bus.mem_we); end
    checks++; if (bus.mem_addr !== 19'h00123) begin
      failures++; $display("FAIL single_addr got=%0h exp=123", bus.mem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b0) begin
      failures++; $display("FAIL single_one_cmd got rd=%b exp=0", bus.mem_rd); end
    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL single_drain got pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_write;
    next_cycle();
    drive(1'b0, '0, 1'b1, 19'h00400, 8'hA5);
    @(negedge clk);
    checks++; if (bus.wr_ack !== 1'b1) begin
      failures++; $display("FAIL write_ack got=%b exp=1", bus.wr_ack); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_rd !== 1'b0) begin
      failures++; $display("FAIL write_strobe got we=%b rd=%b exp we=1 rd=0", bus.mem_we, bus.mem_rd); end
    checks++; if (bus.mem_addr !== 19'h00400 || bus.mem_wdata !== 8'hA5) begin
      failures++; $display("FAIL write_bus got addr=%0h data=%0h exp addr=400 data=a5", bus.mem_addr, bus.mem_wdata); end
    next_cycle();
  endtask

  task automatic test_starvation;
    for (int i = 0; i < int'(SL); i++) begin
      drive(1'b1, 19'h00100 + AW'(i), 1'b1, 19'h00555, 8'h3C);
      push_rd(19'h00100 + AW'(i));
      @(negedge clk);
      checks++; if (bus.vga_busy !== 1'b0 || bus.wr_ack !== 1'b0) begin
        failures++; $display("FAIL starve_block%0d got busy=%b ack=%b exp busy=0 ack=0", i, bus.vga_busy, bus.wr_ack); end
      next_cycle();
    end
    drive(1'b0, '0, 1'b1, 19'h00555, 8'h3C);
    @(negedge clk);
    checks++; if (bus.vga_busy !== 1'b1 || bus.wr_ack !== 1'b1) begin
      failures++; $display("FAIL starve_resv got busy=%b ack=%b exp busy=1 ack=1", bus.vga_busy, bus.wr_ack); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.vga_busy !== 1'b0) begin
      failures++; $display("FAIL starve_release got busy=%b exp=0", bus.vga_busy); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'h00555 || bus.mem_wdata !== 8'h3C) begin
      failures++; $display("FAIL starve_write got we=%b addr=%0h data=%0h exp we=1 addr=555 data=3c",
        bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL starve_drain got pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_counter_hold;
    run_blocked(3, 19'h00200, 19'h00066, 8'h11);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 19'h00210 + AW'(i), 1'b0, '0, '0);
      push_rd(19'h00210 + AW'(i));
      @(negedge clk);
      checks++; if (bus.wr_ack !== 1'b0) begin
        failures++; $display("FAIL hold_noack got=%b exp=0", bus.wr_ack); end
      next_cycle();
    end
    for (int i = 0; i < int'(SL) - 3; i++) begin
      drive(1'b1, 19'h00220 + AW'(i), 1'b1, 19'h00066, 8'h11);
      push_rd(19'h00220 + AW'(i));
      @(negedge clk);
      checks++; if (bus.vga_busy !== 1'b0) begin
        failures++; $display("FAIL hold_block%0d got busy=%b exp=0", i, bus.vga_busy); end
      next_cycle();
    end
    drive(1'b0, '0, 1'b1, 19'h00066, 8'h11);
    @(negedge clk);
    checks++; if (bus.vga_busy !== 1'b1 || bus.wr_ack !== 1'b1) begin
      failures++; $display("FAIL hold_resv got busy=%b ack=%b exp busy=1 ack=1", bus.vga_busy, bus.wr_ack); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL hold_drain got pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_rd_err;
    @(negedge clk);
    checks++; if (bus.rd_err !== 1'b0) begin
      failures++; $display("FAIL rderr_initial got=%b exp=0", bus.rd_err); end
    next_cycle();
    run_blocked(int'(SL), 19'h00300, 19'h00009, 8'h5A);
    drive(1'b1, 19'h00007, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.vga_busy !== 1'b1 || bus.wr_ack !== 1'b0) begin
      failures++; $display("FAIL rderr_busy got busy=%b ack=%b exp busy=1 ack=0", bus.vga_busy, bus.wr_ack); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL rderr_nocmd got rd=%b we=%b exp rd=0 we=0", bus.mem_rd, bus.mem_we); end
    checks++; if (bus.rd_err !== 1'b1 || bus.vga_busy !== 1'b1) begin
      failures++; $display("FAIL rderr_set got err=%b busy=%b exp err=1 busy=1", bus.rd_err, bus.vga_busy); end
    next_cycle();
    drive(1'b0, '0, 1'b1, 19'h00009, 8'h5A);
    @(negedge clk);
    checks++; if (bus.wr_ack !== 1'b1) begin
      failures++; $display("FAIL rderr_ack got=%b exp=1", bus.wr_ack); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    repeat (3) next_cycle();
    @(negedge clk);
    checks++; if (bus.rd_err !== 1'b1 || bus.vga_busy !== 1'b0) begin
      failures++; $display("FAIL rderr_sticky got err=%b busy=%b exp err=1 busy=0", bus.rd_err, bus.vga_busy); end
    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL rderr_drain got pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, AW'(i), 1'b0, '0, '0);
      push_rd(AW'(i));
      @(negedge clk);
      checks++; if (bus.mem_rd !== (i > 0)) begin
        failures++; $display("FAIL b2b_mem_rd%0d got=%b exp=%b", i, bus.mem_rd, (i > 0)); end
      next_cycle();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) next_cycle();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL b2b_drain got pending=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_midflight;
    int vld_seen;
    vld_seen = 0;
    drive(1'b1, 19'h0003C, 1'b0, '0, '0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    next_cycle();
    drive(1'b0, '0, 1'b1, 19'h00077, 8'h99);
    rst = 1'b1;
    #1;
    checks++; if ({bus.mem_rd, bus.mem_we, bus.vga_busy, bus.vga_vld, bus.wr_ack, bus.rd_err} !== 6'b0) begin
      failures++; $display("FAIL midrst_strobes got=%b exp=000000",
        {bus.mem_rd, bus.mem_we, bus.vga_busy, bus.vga_vld, bus.wr_ack, bus.rd_err}); end
    checks++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.vga_data !== '0) begin
      failures++; $display("FAIL midrst_buses got addr=%0h wdata=%0h vdata=%0h exp 0",
        bus.mem_addr, bus.mem_wdata, bus.vga_data); end
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.vga_vld === 1'b1) vld_seen++;
      next_cycle();
    end
    checks++; if (vld_seen != 0) begin
      failures++; $display("FAIL midrst_no_vld got=%0d exp=0", vld_seen); end
  endtask

  initial begin
    for (int i = 0; i < int'(ML); i++) mpipe[i] = 8'hEE;
    test_reset();
    test_single_read();
    test_write();
    test_starvation();
    test_counter_hold();
    test_rd_err();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port frame-buffer memory (VRAM) between two requesters: the VGA display read port (high priority) and a core-side pixel write port (drawing engine).
- Runs in the core clock domain and sits between the vga_controller VRAM interface and the memory.
- Read priority is bounded by a write-starvation guard. The guard reserves a slot by asserting busy toward the VGA side.

Parameters:
- AWIDTH, 19, VRAM address width
- PWIDTH, 8, pixel/data width
- MEM_LATENCY, 2, memory cycles from the registered mem_rd to valid mem_rdata; must be >= 1
- STARVE_LIMIT, 8, number of consecutive blocked cycles for a pending write before a write slot is reserved; must be >= 1

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  asynchronous, active-high reset
- vga_rd  in  1  VGA read request; single-cycle command
- vga_addr  in  AWIDTH  VGA read address
- vga_busy  out  1  registered; VGA must not assert vga_rd while this is high
- vga_data  out  PWIDTH  read data
- vga_vld  out  1  read data valid
- wr_req  in  1  write request; held, with addr and data stable, until wr_ack
- wr_addr  in  AWIDTH  write address
- wr_data  in  PWIDTH  write data
- wr_ack  out  1  combinational; high in the cycle the write is granted
- mem_rd  out  1  registered memory read strobe
- mem_we  out  1  registered memory write strobe
- mem_addr  out  AWIDTH  registered memory address
- mem_wdata  out  PWIDTH  registered memory write data
- mem_rdata  in  PWIDTH  memory read data
- rd_err  out  1  sticky flag: vga_rd was seen while vga_busy was high

Behaviour:
- Reset values: all outputs 0. State = S_NORM, starve counter = 0, read-valid shift register cleared.
- At most one memory command per cycle. mem_rd and mem_we are never high together.
- S_NORM, per cycle:
  - If vga_rd: accept the read. Next cycle mem_rd=1, mem_addr=vga_addr.
  - Else if wr_req: wr_ack=1. Next cycle mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. Counter is cleared.
  - Else: no command; mem strobes are 0.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments on each cycle where vga_rd and wr_req are both high.
  - When the counter equals STARVE_LIMIT-1 and the write is blocked again, go to S_WR_RESV. The counter stays at its value.
  - If wr_req drops without being acked, the counter holds its value. It is cleared only on wr_ack.
- S_WR_RESV:
  - vga_busy = 1 (registered decode of the state).
  - If wr_req: wr_ack=1, issue the write, clear the counter, return to S_NORM.
  - If no wr_req: stay in the state until one arrives.
  - A vga_rd in this state is ignored (no memory command) and sets rd_err, which stays set until reset.
- vga_busy is low in S_NORM.
- Read return path:
  - A MEM_LATENCY+1 stage valid shift register tracks each issued read.
  - vga_data is registered from mem_rdata. vga_vld is high exactly MEM_LATENCY+2 cycles after the vga_rd accept cycle (4 with defaults).
  - Back-to-back reads return back-to-back, one per cycle, in order.
- Write path: a write completes at the memory one cycle after wr_ack. There is no write response.
- Reset mid-operation: in-flight reads are dropped, with no vga_vld ever produced for them. A pending write is not acked.
- Simultaneous vga_rd and wr_req in S_NORM with the counter below threshold: the read wins.

Optional Feature:
- Macro: VRAM_ARB_STAT_EN
- Defined:
  - Adds output stat_stall [15:0], a saturating count (stops at 16'hFFFF) of cycles with wr_req high and no wr_ack.
  - Adds output stat_resv [15:0], a saturating count of entries into S_WR_RESV.
  - Both counters clear on rst_core.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical in both cases.

Decomposition:
- Package vram_arb_pkg holds:
  - the state enum (S_NORM, S_WR_RESV)
  - the stat counter width constant (16)
  - the default latency constants
- Sub-module vram_rd_tracker is natural: the valid shift register plus the data capture register, parameterized by MEM_LATENCY.

Test Plan:
- Single read, vga_rd at cycle 10 with addr 0x00123, memory returns the address LSBs -> mem_rd at cycle 11; vga_vld=1 with vga_data=0x23 at cycle 14.
- Idle VGA side, wr_req addr 0x00400 data 0xA5 -> wr_ack in the same cycle; next cycle mem_we=1, addr 0x00400, wdata 0xA5.
- vga_rd held high continuously plus wr_req pending, STARVE_LIMIT=8 -> 8 blocked cycles, then vga_busy=1, wr_ack asserted in that busy cycle; vga_busy=0 the following cycle.
- Inject vga_rd while vga_busy=1 -> no mem_rd issued; rd_err=1 and stays set until reset.
- 16 back-to-back reads, addresses 0..15 -> 16 consecutive vga_vld cycles returning data 0..15 in order, with no gaps.
- Reset asserted 2 cycles after a read accept -> all outputs 0 immediately (asynchronous); no vga_vld appears after reset release.
